soc_boot_loader: RTL

//  Blackbone bus initiator that copies the boot ROM image into the boot RAM after reset.

---
 rtl/soc_boot_pkg.sv | 14 +
 rtl/soc_boot_loader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/soc_boot_pkg.sv
// Shared types and constants for the boot-image copy engine.
package soc_boot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DRAIN,
    DONE
  } boot_state_t;

  // Byte address = word index << BOOT_WORD_SHIFT (32-bit words).
  localparam int BOOT_WORD_SHIFT = 2;

endpackage

// File: rtl/soc_boot_loader.sv
// Copies the boot ROM image into boot RAM one word per cycle, holding the CPU
// in reset until the copy lands, and accumulating an additive checksum.
module soc_boot_loader
  import soc_boot_pkg::*;
#(
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter int              ROM_WORDS  = 64,
  parameter logic [AW-1:0]   ROM_BASE   = '0,
  parameter logic [AW-1:0]   RAM_BASE   = '0,
  parameter bit              AUTO_START = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic [AW-1:0] rom_addr_o,
  output logic          rom_en_o,
  input  logic [DW-1:0] rom_dout_i,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  input  logic          ram_stall_i,
  output logic          cpu_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] checksum_o
);

  localparam int            IW       = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ROM_WORDS - 1);

  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base,
                                              input logic [IW-1:0] idx);
    return base + (AW'(idx) << BOOT_WORD_SHIFT);
  endfunction

  function automatic logic [DW-1:0] sum_wrap(input logic [DW-1:0] acc,
                                             input logic [DW-1:0] word);
    return acc + word;
  endfunction

  boot_state_t   state;
  logic          auto_pend;
  logic [IW-1:0] rd_idx_p0;
  logic [IW-1:0] wr_idx_p1;
  logic [DW-1:0] wdata_p1;
  logic          vld_p1;
  logic [DW-1:0] checksum;
  logic          busy_q;
  logic          done_q;
  logic          cpu_rst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      auto_pend <= AUTO_START;
      rd_idx_p0 <= '0;
      wr_idx_p1 <= '0;
      wdata_p1  <= '0;
      vld_p1    <= 1'b0;
      checksum  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      auto_pend <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // The auto-start request only counts on the first clock out of reset.
          if (start_i || (state == IDLE && auto_pend)) begin
            state     <= COPY;
            rd_idx_p0 <= '0;
            vld_p1    <= 1'b0;
            checksum  <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
          end
        end
        COPY: begin
          // p0 -> p1: ROM read data lands in the write register unless RAM stalls.
          if (!ram_stall_i) begin
            wdata_p1  <= rom_dout_i;
            wr_idx_p1 <= rd_idx_p0;
            vld_p1    <= 1'b1;
            checksum  <= sum_wrap(checksum, rom_dout_i);
            rd_idx_p0 <= rd_idx_p0 + 1'b1;
            if (rd_idx_p0 == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (vld_p1 && !ram_stall_i) begin
            vld_p1    <= 1'b0;
            state     <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rom_en_o   = (state == COPY);
  assign rom_addr_o = rom_en_o ? word_addr(ROM_BASE, rd_idx_p0) : ROM_BASE;

  assign ram_en_o   = vld_p1;
  assign ram_we_o   = vld_p1;
  assign ram_addr_o = word_addr(RAM_BASE, wr_idx_p1);
  assign ram_din_o  = wdata_p1;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign checksum_o = checksum;

endmodule
